cl_serial_ctrl: RTL and testbench

Sequencer that runs WIDTH-bit logic operations through a single shared 1-bit logic cell (`cl`: 00 AND, 01 OR, 10 XOR, 11 NOT a), one bit per clock, LSB first. The host side uses a start/busy/done handshake. The block owns the cell's select lines and bit operands, latches the operands, counts bits and assembles the result word. It sits between the control unit and the 1-bit logic datapath.

---
 rtl/cl_pkg.sv | 15 +
 rtl/cl.sv | 21 ++
 rtl/cl_serial_ctrl.sv | 98 +++++++++
 tb/tb_cl_serial_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cl_pkg.sv
// Shared encodings for the 1-bit logic cell and its serial sequencer.
package cl_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/cl.sv
// Shared 1-bit logic cell: AND, OR, XOR or NOT a, chosen by the select lines.
module cl
  import cl_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic [1:0] s_i,
  output logic       y_o
);

  // NOTE: every combinational path assigns y_o (default arm included), so no latch is inferred.
  always_comb begin
    case (s_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = ~a_i;
    endcase
  end

endmodule

// File: rtl/cl_serial_ctrl.sv
// Runs a WIDTH-bit logic operation LSB first through one shared 1-bit cell,
// with a start/busy/done handshake toward the control unit.
module cl_serial_ctrl
  import cl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] sa_q, sb_q, acc_q, result_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, zero_q;
  logic             cell_y;

  cl u_cl (
    .a_i (sa_q[0]),
    .b_i (sb_q[0]),
    .s_i (op_q),
    .y_o (cell_y)
  );

  // The accumulator fills from the MSB, so after WIDTH shifts bit i holds cell(a[i], b[i]).
  assign acc_d = {cell_y, acc_q[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      sa_q     <= '0;
      sb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            op_q    <= op;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_q <= acc_d;
            zero_q   <= (acc_d == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_cl_serial_ctrl.sv
// Scoreboard bench for cl_serial_ctrl: expected words queued at start acceptance,
// compared against what the done monitor captures.
module tb_cl_serial_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    int           cyc;
  } rec_t;

  logic         clk, reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero;
  logic [W-1:0] result;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   cyc = 0;
  int   busy_total = 0;
  int   total = 0;
  int   bad = 0;

  cl_serial_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (done === 1'b1) begin
      r.res = result;
      r.z   = zero;
      r.cyc = cyc;
      obs_q.push_back(r);
    end
    if (busy === 1'b1) busy_total++;
  end

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // Drives start for one edge; returns the cycle count right after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int c0);
    rec_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    e.res = model(o, x, y);
    e.z   = (e.res == '0);
    e.cyc = c0 + W;
    exp_q.push_back(e);
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 40 * W && obs_q.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== '0)  begin bad++; $display("FAIL reset_result got=%h want=00", result); end
    total++; if (zero !== 1'b1)  begin bad++; $display("FAIL reset_zero got=%b want=1", zero); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ops(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int k = 0; k < 4; k++) begin
      int   c0, b0;
      rec_t e, g;
      logic [1:0] o;
      o = k[1:0];
      issue(o, x, y, c0);
      b0 = busy_total;
      wait_obs(1);
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL ops_timeout op=%0d got=no_done want=done", k);
      end else begin
        g = obs_q.pop_front();
        if (g.res !== e.res) begin bad++; $display("FAIL ops_result op=%0d got=%h want=%h", k, g.res, e.res); end
        total++; if (g.z !== e.z) begin bad++; $display("FAIL ops_zero op=%0d got=%b want=%b", k, g.z, e.z); end
        total++; if (g.cyc !== e.cyc) begin bad++; $display("FAIL ops_latency op=%0d got=%0d want=%0d", k, g.cyc - c0, W); end
        total++; if (busy_total - b0 !== W) begin bad++; $display("FAIL ops_busy_cycles op=%0d got=%0d want=%0d", k, busy_total - b0, W); end
      end
    end
  endtask

  task automatic test_zero;
    logic [1:0] ops [2] = '{2'b00, 2'b10};
    for (int k = 0; k < 2; k++) begin
      int   c0;
      rec_t e, g;
      issue(ops[k], 8'hF0, 8'h0F, c0);
      wait_obs(1);
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL zero_timeout op=%0d got=no_done want=done", ops[k]);
      end else begin
        g = obs_q.pop_front();
        if (g.res !== e.res) begin bad++; $display("FAIL zero_result op=%0d got=%h want=%h", ops[k], g.res, e.res); end
        total++; if (g.z !== e.z) begin bad++; $display("FAIL zero_flag op=%0d got=%b want=%b", ops[k], g.z, e.z); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]   vo [3] = '{2'b01, 2'b11, 2'b10};
    logic [W-1:0] va [3] = '{8'h3C, 8'h0F, 8'hAA};
    logic [W-1:0] vb [3] = '{8'hA5, 8'h77, 8'h55};
    @(negedge clk);
    start = 1'b1;
    op = vo[0]; a = va[0]; b = vb[0];
    for (int k = 0; k < 3; k++) begin
      rec_t e;
      @(posedge clk);
      #1;
      e.res = model(vo[k], va[k], vb[k]);
      e.z   = (e.res == '0);
      e.cyc = cyc + W;
      exp_q.push_back(e);
      if (k == 2) begin
        start = 1'b0;
      end else begin
        for (int j = 0; j < W; j++) begin
          @(posedge clk);
          #1;
          a = W'($urandom); b = W'($urandom); op = 2'($urandom_range(0, 3));
        end
        @(posedge clk);
        #1;
        op = vo[k+1]; a = va[k+1]; b = vb[k+1];
      end
    end
    wait_obs(3);
    repeat (3 * W) @(negedge clk);
    #1;
    total++;
    if (obs_q.size() !== 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", obs_q.size()); end
    for (int k = 0; k < 3; k++) begin
      rec_t e, g;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL b2b_missing idx=%0d got=no_done want=done", k);
      end else begin
        g = obs_q.pop_front();
        if (g.res !== e.res) begin bad++; $display("FAIL b2b_result idx=%0d got=%h want=%h", k, g.res, e.res); end
        total++; if (g.cyc !== e.cyc) begin bad++; $display("FAIL b2b_timing idx=%0d got=%0d want=%0d", k, g.cyc, e.cyc); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_run;
    int   c0;
    rec_t e, g;
    issue(2'b00, 8'hCA, 8'h5F, c0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    void'(exp_q.pop_back());
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    total++; if (result !== '0) begin bad++; $display("FAIL abort_result got=%h want=00", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL abort_zero got=%b want=1", zero); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * W) @(negedge clk);
    #1;
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL abort_spurious_done got=%0d want=0", obs_q.size()); end
    obs_q.delete();
    issue(2'b00, 8'hCA, 8'h5F, c0);
    wait_obs(1);
    e = exp_q.pop_front();
    total++;
    if (obs_q.size() == 0) begin
      bad++; $display("FAIL restart_timeout got=no_done want=done");
    end else begin
      g = obs_q.pop_front();
      if (g.res !== e.res) begin bad++; $display("FAIL restart_result got=%h want=%h", g.res, e.res); end
      total++; if (g.z !== e.z) begin bad++; $display("FAIL restart_zero got=%b want=%b", g.z, e.z); end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    test_reset();
    test_ops(8'hCA, 8'h5F);
    test_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
